// File: rtl/score_display.sv
// Hit/miss scoreboard with a multiplexed 4-digit active-low 7-segment display.
// Define SCORE_LZB_EN to blank a tens digit that reads 0.
module score_display #(
  parameter int unsigned REFRESH_DIV = 6250,
  parameter int unsigned MAX_MISSES  = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_strobe,
  input  logic       paddle_hit,
  input  logic       floor_hit,
  input  logic       clear,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       game_over
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PrescLast = PW'(REFRESH_DIV - 1);
  localparam logic [6:0] MaxMiss = 7'(MAX_MISSES);
  localparam logic [6:0] SegOff = 7'h7F;
  localparam logic [3:0] AnOff = 4'hF;

  // Scores are packed BCD: [7:4] tens, [3:0] ones.
  logic [7:0]    hits_q, hits_d;
  logic [7:0]    miss_q, miss_d;
  logic          prev_hit_q, prev_hit_d;
  logic          prev_floor_q, prev_floor_d;
  logic          game_over_q, game_over_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    idx_q, idx_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic       hit_edge, miss_edge, slot_wrap;
  logic [6:0] miss_bin;
  logic [3:0] digit;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic saturate);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = saturate ? v : 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SegOff;
    endcase
    return s;
  endfunction

  assign hit_edge  = frame_strobe & paddle_hit & ~prev_hit_q;
  assign miss_edge = frame_strobe & floor_hit & ~prev_floor_q;
  assign miss_bin  = 7'(miss_q[7:4]) * 7'd10 + 7'(miss_q[3:0]);
  assign slot_wrap = (presc_q == PrescLast);

  // Score keeping: clear wins over a coincident strobe; game over freezes only the counts.
  always_comb begin
    hits_d       = hits_q;
    miss_d       = miss_q;
    prev_hit_d   = prev_hit_q;
    prev_floor_d = prev_floor_q;
    game_over_d  = (miss_bin >= MaxMiss);
    if (clear) begin
      hits_d       = 8'h00;
      miss_d       = 8'h00;
      prev_hit_d   = 1'b0;
      prev_floor_d = 1'b0;
      game_over_d  = 1'b0;
    end else if (frame_strobe) begin
      prev_hit_d   = paddle_hit;
      prev_floor_d = floor_hit;
      if (!game_over_q) begin
        if (hit_edge) begin
          hits_d = bcd_inc(hits_q, 1'b0);
        end
        if (miss_edge) begin
          miss_d = bcd_inc(miss_q, 1'b1);
        end
      end
    end
  end

  always_comb begin
    unique case (idx_q)
      2'd3:    digit = hits_q[7:4];
      2'd2:    digit = hits_q[3:0];
      2'd1:    digit = miss_q[7:4];
      default: digit = miss_q[3:0];
    endcase
  end

  // Display scan: the cycle after the index moves is blanked to avoid ghosting.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    an_d    = ~(4'b0001 << idx_q);
    seg_d   = seg_decode(digit);
`ifdef SCORE_LZB_EN
    if (idx_q[0] && (digit == 4'd0)) begin
      seg_d = SegOff;
    end
`endif
    if (slot_wrap) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
      an_d    = AnOff;
      seg_d   = SegOff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q       <= 8'h00;
      miss_q       <= 8'h00;
      prev_hit_q   <= 1'b0;
      prev_floor_q <= 1'b0;
      game_over_q  <= 1'b0;
      presc_q      <= '0;
      idx_q        <= 2'd0;
      seg_q        <= SegOff;
      an_q         <= AnOff;
    end else begin
      hits_q       <= hits_d;
      miss_q       <= miss_d;
      prev_hit_q   <= prev_hit_d;
      prev_floor_q <= prev_floor_d;
      game_over_q  <= game_over_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with a fast refresh (REFRESH_DIV=4); reads scores off seg/an.
module tb_score_display;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_strobe = 1'b0;
  logic       paddle_hit = 1'b0;
  logic       floor_hit = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       game_over;

  int checks = 0;
  int failures = 0;
  int h_exp = 0;
  int m_exp = 0;

  score_display #(
    .REFRESH_DIV(4),
    .MAX_MISSES (9)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_strobe(frame_strobe),
    .paddle_hit  (paddle_hit),
    .floor_hit   (floor_hit),
    .clear       (clear),
    .seg         (seg),
    .an          (an),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] tens7(input int d);
`ifdef SCORE_LZB_EN
    if (d == 0) return 7'h7F;
`endif
    return seg7(d);
  endfunction

  // {an[3] seg, an[2] seg, an[1] seg, an[0] seg}
  function automatic logic [27:0] exp_disp(input int h, input int m);
    return {tens7(h / 10), seg7(h % 10), tens7(m / 10), seg7(m % 10)};
  endfunction

  task automatic frame(input logic p, input logic f);
    @(negedge clk);
    frame_strobe = 1'b1;
    paddle_hit   = p;
    floor_hit    = f;
    @(negedge clk);
    frame_strobe = 1'b0;
    paddle_hit   = 1'b0;
    floor_hit    = 1'b0;
  endtask

  task automatic edges(input int n, input logic p, input logic f);
    for (int i = 0; i < n; i++) begin
      frame(p, f);
      frame(1'b0, 1'b0);
    end
  endtask

  task automatic read_display(output logic [27:0] d, output bit ok);
    logic [3:0] found;
    found = 4'h0;
    d = {4{7'h7F}};
    repeat (4) @(negedge clk);
    for (int i = 0; i < 64 && found != 4'hF; i++) begin
      @(negedge clk);
      case (an)
        4'h7: begin d[27:21] = seg; found[3] = 1'b1; end
        4'hB: begin d[20:14] = seg; found[2] = 1'b1; end
        4'hD: begin d[13:7] = seg;  found[1] = 1'b1; end
        4'hE: begin d[6:0] = seg;   found[0] = 1'b1; end
        default: ;
      endcase
    end
    ok = (found == 4'hF);
  endtask

  task automatic test_reset;
    logic [27:0] d;
    bit ok;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'hF) begin failures++; $display("FAIL reset_an: got %h want F", an); end
    checks++;
    if (seg !== 7'h7F) begin failures++; $display("FAIL reset_seg: got %h want 7F", seg); end
    checks++;
    if (game_over !== 1'b0) begin failures++; $display("FAIL reset_go: got %b want 0", game_over); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (an !== 4'hE) begin failures++; $display("FAIL reset_first_slot: an got %h want E", an); end
    h_exp = 0; m_exp = 0;
    read_display(d, ok);
    checks++;
    if (!ok || d !== exp_disp(h_exp, m_exp)) begin
      failures++; $display("FAIL reset_disp: got %h want %h ok=%0d", d, exp_disp(h_exp, m_exp), ok);
    end
  endtask

  task automatic test_edge_count;
    logic [27:0] d;
    bit ok;
    repeat (5) frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);
    frame(1'b1, 1'b0);
    frame(1'b0, 1'b0);
    h_exp = 2;
    read_display(d, ok);
    checks++;
    if (!ok || d !== exp_disp(h_exp, m_exp)) begin
      failures++; $display("FAIL edge_count: got %h want %h ok=%0d", d, exp_disp(h_exp, m_exp), ok);
    end
  endtask

  task automatic test_hit_wrap;
    logic [27:0] d;
    bit ok;
    edges(8, 1'b1, 1'b0);
    h_exp = 10;
    read_display(d, ok);
    checks++;
    if (!ok || d !== exp_disp(h_exp, m_exp)) begin
      failures++; $display("FAIL carry_09_10: got %h want %h ok=%0d", d, exp_disp(h_exp, m_exp), ok);
    end
    edges(89, 1'b1, 1'b0);
    h_exp = 99;
    read_display(d, ok);
    checks++;
    if (!ok || d !== exp_disp(h_exp, m_exp)) begin
      failures++; $display("FAIL hits_99: got %h want %h ok=%0d", d, exp_disp(h_exp, m_exp), ok);
    end
    edges(1, 1'b1, 1'b0);
    h_exp = 0;
    read_display(d, ok);
    checks++;
    if (!ok || d !== exp_disp(h_exp, m_exp)) begin
      failures++; $display("FAIL hits_wrap: got %h want %h ok=%0d", d, exp_disp(h_exp, m_exp), ok);
    end
  endtask

  task automatic test_both_and_game_over;
    logic [27:0] d;
    bit ok;
    edges(1, 1'b1, 1'b1);
    h_exp = 1; m_exp = 1;
    read_display(d, ok);
    checks++;
    if (!ok || d !== exp_disp(h_exp, m_exp)) begin
      failures++; $display("FAIL same_cycle: got %h want %h ok=%0d", d, exp_disp(h_exp, m_exp), ok);
    end
    edges(7, 1'b0, 1'b1);
    m_exp = 8;
    checks++;
    if (game_over !== 1'b0) begin failures++; $display("FAIL go_at_8: got %b want 0", game_over); end
    @(negedge clk);
    frame_strobe = 1'b1;
    floor_hit    = 1'b1;
    @(negedge clk);
    frame_strobe = 1'b0;
    floor_hit    = 1'b0;
    m_exp = 9;
    checks++;
    if (game_over !== 1'b0) begin failures++; $display("FAIL go_latency: got %b want 0", game_over); end
    @(negedge clk);
    checks++;
    if (game_over !== 1'b1) begin failures++; $display("FAIL go_assert: got %b want 1", game_over); end
    frame(1'b0, 1'b0);
    edges(3, 1'b1, 1'b1);
    read_display(d, ok);
    checks++;
    if (!ok || d !== exp_disp(h_exp, m_exp)) begin
      failures++; $display("FAIL frozen: got %h want %h ok=%0d", d, exp_disp(h_exp, m_exp), ok);
    end
    checks++;
    if (game_over !== 1'b1) begin failures++; $display("FAIL go_hold: got %b want 1", game_over); end
  endtask

  task automatic test_reset_midrun;
    logic [27:0] d;
    bit ok;
    @(negedge clk);
    frame_strobe = 1'b1;
    paddle_hit   = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || game_over !== 1'b0) begin
      failures++;
      $display("FAIL midrun_rst: an=%h seg=%h go=%b want F 7F 0", an, seg, game_over);
    end
    @(negedge clk);
    frame_strobe = 1'b0;
    paddle_hit   = 1'b0;
    rst          = 1'b0;
    @(negedge clk);
    checks++;
    if (an !== 4'hE) begin failures++; $display("FAIL midrun_first_slot: an got %h want E", an); end
    h_exp = 0; m_exp = 0;
    read_display(d, ok);
    checks++;
    if (!ok || d !== exp_disp(h_exp, m_exp)) begin
      failures++; $display("FAIL midrun_disp: got %h want %h ok=%0d", d, exp_disp(h_exp, m_exp), ok);
    end
  endtask

  task automatic test_clear;
    logic [27:0] d;
    bit ok;
    edges(3, 1'b1, 1'b0);
    edges(2, 1'b0, 1'b1);
    h_exp = 3; m_exp = 2;
    read_display(d, ok);
    checks++;
    if (!ok || d !== exp_disp(h_exp, m_exp)) begin
      failures++; $display("FAIL pre_clear: got %h want %h ok=%0d", d, exp_disp(h_exp, m_exp), ok);
    end
    @(negedge clk);
    clear        = 1'b1;
    frame_strobe = 1'b1;
    paddle_hit   = 1'b1;
    floor_hit    = 1'b1;
    @(negedge clk);
    clear        = 1'b0;
    frame_strobe = 1'b0;
    paddle_hit   = 1'b0;
    floor_hit    = 1'b0;
    h_exp = 0; m_exp = 0;
    read_display(d, ok);
    checks++;
    if (!ok || d !== exp_disp(h_exp, m_exp)) begin
      failures++; $display("FAIL clear_priority: got %h want %h ok=%0d", d, exp_disp(h_exp, m_exp), ok);
    end
    edges(9, 1'b0, 1'b1);
    m_exp = 9;
    @(negedge clk);
    checks++;
    if (game_over !== 1'b1) begin failures++; $display("FAIL go_before_clear: got %b want 1", game_over); end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_exp = 0;
    checks++;
    if (game_over !== 1'b0) begin failures++; $display("FAIL go_clear: got %b want 0", game_over); end
  endtask

  task automatic test_scan;
    logic [27:0] d;
    logic [3:0]  s [16];
    logic [3:0]  want;
    bit ok;
    int idx0;
    bit seen;
    edges(42, 1'b1, 1'b0);
    edges(7, 1'b0, 1'b1);
    h_exp = 42; m_exp = 7;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (an === 4'hF) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL scan_blank_found: got none want F within 40"); end
    s[0] = an;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      s[i] = an;
    end
    case (s[1])
      4'hE: idx0 = 0;
      4'hD: idx0 = 1;
      4'hB: idx0 = 2;
      4'h7: idx0 = 3;
      default: idx0 = -1;
    endcase
    checks++;
    if (idx0 < 0) begin failures++; $display("FAIL scan_first: an got %h want E/D/B/7", s[1]); idx0 = 0; end
    for (int k = 0; k < 4; k++) begin
      want = ~(4'b0001 << ((idx0 + k) % 4));
      checks++;
      if (s[4 * k] !== 4'hF) begin
        failures++; $display("FAIL scan_blank%0d: an got %h want F", k, s[4 * k]);
      end
      for (int j = 1; j < 4; j++) begin
        checks++;
        if (s[4 * k + j] !== want) begin
          failures++; $display("FAIL scan_slot%0d_%0d: an got %h want %h", k, j, s[4 * k + j], want);
        end
      end
    end
    read_display(d, ok);
    checks++;
    if (!ok || d !== exp_disp(h_exp, m_exp)) begin
      failures++; $display("FAIL scan_disp: got %h want %h ok=%0d", d, exp_disp(h_exp, m_exp), ok);
    end
  endtask

  initial begin
    test_reset();
    test_edge_count();
    test_hit_wrap();
    test_both_and_game_over();
    test_reset_midrun();
    test_clear();
    test_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameter REFRESH_DIV, default 6250, clk cycles per digit slot (4 kHz digit rate at 25 MHz).
REQ-002 Parameter MAX_MISSES, default 9, miss count (1..99) at which game_over asserts.
REQ-003 clk  input  1  pixel clock; sole clock, all state on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 frame_strobe  input  1  one-cycle pulse once per video frame, from the game's collision-reset strobe.
REQ-006 paddle_hit  input  1  level; ball touched paddle this frame; valid when frame_strobe is high.
REQ-007 floor_hit  input  1  level; ball touched bottom border this frame (miss); valid when frame_strobe is high.
REQ-008 clear  input  1  synchronous score clear, level.
REQ-009 seg  output  7  active-low segments, bit6..0 = g..a.
REQ-010 an  output  4  active-low digit anodes; an[3] is leftmost.
REQ-011 game_over  output  1  high while miss count >= MAX_MISSES.

Function
REQ-012 Hits and misses SHALL each be held as 2-digit BCD (tens, ones), range 00..99.
REQ-013 On each frame_strobe cycle, paddle_hit and floor_hit SHALL be sampled into prev_hit/prev_floor.
REQ-014 Hits SHALL increment by 1 when frame_strobe=1, paddle_hit=1, prev_hit=0; a contact spanning several frames counts once.
REQ-015 Misses SHALL increment under the same rule using floor_hit/prev_floor.
REQ-016 Hit and miss increments in the same frame_strobe cycle SHALL both take effect.
REQ-017 BCD increment: ones 9 -> 0 with tens+1; hits 99 -> 00 (wrap); misses saturate at 99.
REQ-018 While game_over=1, neither counter SHALL change; edge history still updates.
REQ-019 game_over SHALL be registered, asserting the cycle after misses reach MAX_MISSES (binary value of tens*10+ones).
REQ-020 clear=1 SHALL zero both counters, prev_hit, prev_floor and game_over on the next edge; clear takes priority over a simultaneous frame_strobe.
REQ-021 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap; on wrap the 2-bit digit index SHALL advance 0->1->2->3->0.
REQ-022 Digit map: index 3 = hits tens, 2 = hits ones, 1 = misses tens, 0 = misses ones.
REQ-023 Decode (seg hex): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10.
REQ-024 For the one cycle following each index change, an SHALL be 4'hF (anti-ghosting blank); otherwise exactly one an bit is low.
REQ-025 seg and an SHALL be registered; the displayed value lags a counter change by at most one digit slot + 1 cycle.
REQ-026 When game_over=1, all four digits SHALL show the frozen score unchanged; no blinking.

Reset
REQ-027 rst=1 SHALL immediately force: counters 00/00, prev_hit=0, prev_floor=0, game_over=0, prescaler=0, index=0, an=4'hF, seg=7'h7F.
REQ-028 After rst deasserts, the first digit slot SHALL be index 0, beginning after the one-cycle blank.
REQ-029 rst asserted mid-slot or mid-increment SHALL discard any pending increment; no partial BCD state survives.

Configuration
REQ-030 Macro SCORE_LZB_EN defined: a tens digit equal to 0 SHALL be blanked (seg=7'h7F, anode still driven); ones digits never blank.
REQ-031 SCORE_LZB_EN undefined: tens digits SHALL always display, including 0.

Verification
REQ-032 rst pulse mid-run -> an=F, seg=7F, game_over=0 asynchronously; first slot after release is index 0.
REQ-033 paddle_hit high for 5 consecutive frame_strobes, then low, then high for 1 -> hits = 02.
REQ-034 Preload hits to 99 via 99 hit edges, then one more edge -> hits 00; carry 09->10 checked on the way.
REQ-035 Same-cycle paddle_hit and floor_hit edges -> hits+1 and misses+1; 9th miss edge -> game_over=1 next cycle; further edges leave counts unchanged; clear -> 00/00, game_over=0.
REQ-036 REFRESH_DIV=4, free-run -> an sequence E,D,B,7 with F for one cycle between each; seg for hits=42 shows 19 then 24 on an[3]/an[2].
REQ-037 SCORE_LZB_EN defined, misses=07 -> an[1] slot seg=7F, an[0] slot seg=78; undefined -> an[1] slot seg=40.
